pwm_duty_ramp: RTL and testbench
================================

Name: pwm_duty_ramp

Overview:
Soft-start/soft-stop duty controller that sits directly upstream of the PWM generator and drives its duty input. It accepts a target duty over a valid/ready handshake. It then walks its registered duty output one LSB at a time toward that target, and applies every change only at a PWM period boundary. Its internal free-running period counter resets and wraps exactly like the PWM generator's counter, so the two stay aligned from reset.

Parameters:
DUTY_W, 3, width of duty values. 2^DUTY_W-1 must be <= PERIOD.
PERIOD, 8, PWM period in clocks. Must match the downstream PWM generator. Must be >= 2.
STEP_PERIODS, 4, number of PWM periods between successive duty steps. Must be >= 1.

Ports:
clk_i  input  1  system clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
tgt_duty_i  input  DUTY_W  requested target duty
tgt_valid_i  input  1  target request valid
tgt_ready_o  output  1  block can accept a target (state IDLE)
duty_o  output  DUTY_W  registered duty, connects to the PWM generator's duty input
busy_o  output  1  ramp in progress (state RAMP)
period_end_o  output  1  high during the last clock of each PWM period

Behaviour:
- Clocking and reset: one clock, clk_i. Asynchronous active-low reset rst_n_i; all state clears immediately on assertion.
- Reset values: duty_o=0, state=IDLE, tgt_ready_o=1, busy_o=0, period counter=0, step counter=0, target register=0. period_end_o=0 (counter is 0).
- Period counter:
  - Width ceil(log2(PERIOD)); free-running in every state.
  - Counts 0..PERIOD-1, then wraps to 0.
  - period_end_o = (count == PERIOD-1), combinational from the counter.
- Duty update rule: duty_o changes only on the clock edge that ends a cycle with period_end_o=1. The new duty therefore takes effect at count 0 of the next period, so no partial periods occur.
- State machine (2 states):
  - IDLE: tgt_ready_o=1, busy_o=0, step counter held at 0.
    - On tgt_valid_i & tgt_ready_o, latch tgt_duty_i.
    - If tgt_duty_i == duty_o, stay in IDLE (request completes with no effect).
    - Otherwise go to RAMP next cycle.
  - RAMP: tgt_ready_o=0, busy_o=1.
    - At each period end, step counter increments.
    - When the step counter equals STEP_PERIODS-1 at a period end:
      - step counter clears to 0;
      - duty_o moves +1 if target > duty_o, or -1 if target < duty_o;
      - if the new duty equals the target, state returns to IDLE on the same edge.
- Ramp timing:
  - The period end occurring in the acceptance cycle itself is not counted.
  - The first step occurs at the STEP_PERIODS-th period end after acceptance.
  - A ramp of |T-d| LSBs takes exactly |T-d| steps.
  - busy_o falls on the same edge on which duty_o reaches the target.
- Handshake: tgt_valid_i while in RAMP is ignored (ready low). Requests are not queued, and the target cannot be changed mid-ramp.
- Arithmetic: unsigned compare; a step is always ±1. No overflow is possible, because the target is within range and steps stop at the target.
- Simultaneous events: valid asserted in the same cycle the ramp completes is ignored, since ready is still 0 in that cycle. It is accepted in the following cycle if still asserted.
- Reset mid-ramp: duty_o returns to 0 immediately (asynchronously), state goes to IDLE, counters clear, and the pending target is discarded.

Test Plan:
1. Reset release, no requests -> duty_o=0, tgt_ready_o=1, busy_o=0; period_end_o high at cycles 7, 15, 23… after reset release (PERIOD=8).
2. Idle at duty 0, request target 5 (STEP_PERIODS=4) -> busy_o=1 next cycle. duty_o steps 1,2,3,4,5, one step every 32 clocks, each change on a period-end edge. busy_o and tgt_ready_o change together on the edge where duty_o becomes 5.
3. At duty 5, request target 2 -> duty_o steps 4,3,2 at 32-clock spacing, then IDLE. Downstream PWM high time follows 4/8, 3/8, 2/8 with no partial periods.
4. At duty 2, request target 2 -> accepted in one cycle, busy_o stays 0, duty_o unchanged across 64 clocks.
5. During the ramp 0->5, hold tgt_valid_i=1 with tgt_duty_i=1 -> ignored, ramp still ends at 5. The held request is then accepted the cycle after busy_o falls and ramps down to 1.
6. Assert rst_n_i low mid-ramp at duty 3, off a clock edge -> duty_o=0 and busy_o=0 immediately. After release, period_end_o is again high at cycle 7.

Source files
------------

// File: rtl/pwm_duty_ramp_if.sv
// Target-duty request handshake between a controller and pwm_duty_ramp.
interface pwm_duty_ramp_if #(
    parameter int unsigned DUTY_W = 3
);
    logic [DUTY_W-1:0] tgt_duty_i;
    logic              tgt_valid_i;
    logic              tgt_ready_o;

    modport master (
        output tgt_duty_i,
        output tgt_valid_i,
        input  tgt_ready_o
    );

    modport slave (
        input  tgt_duty_i,
        input  tgt_valid_i,
        output tgt_ready_o
    );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Soft-start/stop duty controller: walks duty_o one LSB per STEP_PERIODS PWM
// periods toward an accepted target, changing only on period boundaries.
module pwm_duty_ramp #(
    parameter int unsigned DUTY_W       = 3,
    parameter int unsigned PERIOD       = 8,
    parameter int unsigned STEP_PERIODS = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    pwm_duty_ramp_if.slave    tgt,
    output logic [DUTY_W-1:0] duty_o,
    output logic              busy_o,
    output logic              period_end_o
);
    localparam int unsigned CNT_W  = $clog2(PERIOD);
    localparam int unsigned STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic [DUTY_W-1:0]  tgt_q, tgt_d;

    assign period_end_o    = (cnt_q == CNT_LAST);
    assign duty_o          = duty_q;
    assign busy_o          = (state_q == RAMP);
    assign tgt.tgt_ready_o = (state_q == IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            duty_q  <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        cnt_d   = period_end_o ? '0 : cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                // Step counting starts only in RAMP, so a period end in the
                // acceptance cycle itself is never counted.
                step_d = '0;
                if (tgt.tgt_valid_i) begin
                    tgt_d = tgt.tgt_duty_i;
                    if (tgt.tgt_duty_i != duty_q) begin
                        state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (period_end_o) begin
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        duty_d = (tgt_q > duty_q) ? duty_q + DUTY_W'(1)
                                                  : duty_q - DUTY_W'(1);
                        if (duty_d == tgt_q) begin
                            state_d = IDLE;
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with a period-counting reference model.
module tb_pwm_duty_ramp;
    localparam int unsigned DUTY_W       = 3;
    localparam int unsigned PERIOD       = 8;
    localparam int unsigned STEP_PERIODS = 4;

    logic              clk_i;
    logic              rst_n_i;
    logic [DUTY_W-1:0] duty_o;
    logic              busy_o;
    logic              period_end_o;

    int checks = 0;
    int errors = 0;

    pwm_duty_ramp_if #(.DUTY_W(DUTY_W)) tif ();

    pwm_duty_ramp #(
        .DUTY_W      (DUTY_W),
        .PERIOD      (PERIOD),
        .STEP_PERIODS(STEP_PERIODS)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .tgt         (tif.slave),
        .duty_o      (duty_o),
        .busy_o      (busy_o),
        .period_end_o(period_end_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: duty is start +/- (period ends since acceptance) / STEP_PERIODS.
    int m_cnt, m_duty, m_tgt, m_start, m_pends;
    logic m_busy;

    always @(posedge clk_i or negedge rst_n_i) begin : model
        int nd, nt, ns, np, steps;
        logic nb;
        if (!rst_n_i) begin
            m_cnt   <= 0;
            m_duty  <= 0;
            m_tgt   <= 0;
            m_start <= 0;
            m_pends <= 0;
            m_busy  <= 1'b0;
        end else begin
            nd = m_duty; nt = m_tgt; ns = m_start; np = m_pends; nb = m_busy;
            if (!m_busy) begin
                if (tif.tgt_valid_i) begin
                    nt = int'(tif.tgt_duty_i);
                    if (nt != m_duty) begin
                        nb = 1'b1;
                        ns = m_duty;
                        np = 0;
                    end
                end
            end else if (m_cnt == PERIOD - 1) begin
                np    = m_pends + 1;
                steps = np / STEP_PERIODS;
                nd    = (m_tgt > m_start) ? m_start + steps : m_start - steps;
                if (nd == m_tgt) nb = 1'b0;
            end
            m_duty  <= nd;
            m_tgt   <= nt;
            m_start <= ns;
            m_pends <= np;
            m_busy  <= nb;
            m_cnt   <= (m_cnt + 1) % PERIOD;
        end
    end

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            chk("cyc_duty",  int'(duty_o), m_duty);
            chk("cyc_busy",  int'(busy_o), int'(m_busy));
            chk("cyc_ready", int'(tif.tgt_ready_o), int'(!m_busy));
            chk("cyc_pend",  int'(period_end_o), int'(m_cnt == PERIOD - 1));
        end
    end

    // Called at the negedge right after the acceptance edge.
    task automatic wait_ramp(input string name, input int exp_n, input int exp_first,
                             input int exp_duty);
        logic [DUTY_W-1:0] d0;
        int n;
        int first;
        d0 = duty_o;
        n = 0;
        first = -1;
        chk({name, "_busy0"}, int'(busy_o), 1);
        while (busy_o && n < 1000) begin
            @(negedge clk_i);
            n++;
            if (first < 0 && duty_o != d0) first = n;
        end
        chk({name, "_len"},   n, exp_n);
        chk({name, "_first"}, first, exp_first);
        chk({name, "_duty"},  int'(duty_o), exp_duty);
        chk({name, "_ready"}, int'(tif.tgt_ready_o), 1);
    endtask

    initial begin
        int n;
        rst_n_i         = 1'b0;
        tif.tgt_valid_i = 1'b0;
        tif.tgt_duty_i  = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_duty",  int'(duty_o), 0);
        chk("rst_ready", int'(tif.tgt_ready_o), 1);
        chk("rst_busy",  int'(busy_o), 0);
        chk("rst_pend",  int'(period_end_o), 0);
        rst_n_i = 1'b1;

        // Idle: period end at cycle 7 after release
        repeat (7) @(negedge clk_i);
        chk("idle_pend7", int'(period_end_o), 1);
        repeat (1) @(negedge clk_i);
        chk("idle_pend8", int'(period_end_o), 0);
        repeat (8) @(negedge clk_i);

        // Ramp 0 -> 5
        tif.tgt_valid_i = 1'b1;
        tif.tgt_duty_i  = 3'd5;
        @(negedge clk_i);
        tif.tgt_valid_i = 1'b0;
        wait_ramp("up5", 159, 31, 5);

        // Ramp 5 -> 2
        tif.tgt_valid_i = 1'b1;
        tif.tgt_duty_i  = 3'd2;
        @(negedge clk_i);
        tif.tgt_valid_i = 1'b0;
        wait_ramp("dn2", 95, 31, 2);

        // Same target: no ramp
        tif.tgt_valid_i = 1'b1;
        tif.tgt_duty_i  = 3'd2;
        @(negedge clk_i);
        tif.tgt_valid_i = 1'b0;
        chk("same_busy",  int'(busy_o), 0);
        chk("same_ready", int'(tif.tgt_ready_o), 1);
        repeat (63) @(negedge clk_i);
        chk("same_duty", int'(duty_o), 2);

        // Reset mid-ramp at duty 3
        tif.tgt_valid_i = 1'b1;
        tif.tgt_duty_i  = 3'd5;
        @(negedge clk_i);
        tif.tgt_valid_i = 1'b0;
        n = 0;
        while (duty_o != 3'd3 && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        chk("mid_reach3", int'(duty_o), 3);
        #2 rst_n_i = 1'b0;
        #1;
        chk("mid_rst_duty",  int'(duty_o), 0);
        chk("mid_rst_busy",  int'(busy_o), 0);
        chk("mid_rst_ready", int'(tif.tgt_ready_o), 1);
        chk("mid_rst_pend",  int'(period_end_o), 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (7) @(negedge clk_i);
        chk("rel_pend7", int'(period_end_o), 1);
        repeat (9) @(negedge clk_i);

        // Ramp 0 -> 5 with a request held high throughout, then 5 -> 1
        tif.tgt_valid_i = 1'b1;
        tif.tgt_duty_i  = 3'd5;
        @(negedge clk_i);
        tif.tgt_duty_i  = 3'd1;
        wait_ramp("held_up5", 159, 31, 5);
        @(negedge clk_i);
        tif.tgt_valid_i = 1'b0;
        wait_ramp("held_dn1", 127, 31, 1);

        repeat (4) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
